// File: rtl/match_pkg.sv
// match_pkg: shared types for the color-matching game sequencer.
// Holds the FSM state enum and the per-square display codes.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_WAIT_SECOND,
    ST_COMPARE,
    ST_SHOW,
    ST_DONE
  } state_t;

  localparam logic [1:0] SQ_HIDDEN   = 2'b00;
  localparam logic [1:0] SQ_CURSOR   = 2'b01;
  localparam logic [1:0] SQ_REVEALED = 2'b10;
  localparam logic [1:0] SQ_MATCHED  = 2'b11;

endpackage

// File: rtl/show_timer.sv
// show_timer: down-counter holding a mismatched pair visible.
// A load presets SHOW_CYCLES-1; abort forces it idle; o_done flags zero.
module show_timer #(
  parameter int SHOW_CYCLES = 25_000_000
) (
  input  logic clk25MHz,
  input  logic rst,
  input  logic i_load,
  input  logic i_abort,
  output logic o_done
);

  localparam int CNT_W = $clog2(SHOW_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  // Count down toward zero after a load; abort wins over load.
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(SHOW_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/match_controller.sv
// match_controller: color-matching game sequencer.
// Reveals squares two at a time, locks matched pairs, hides mismatches
// after a hold time, and drives 2-bit per-square display codes.
// Optional feature macro: MOVE_COUNT_EN adds the saturating move_cnt port.
//
// state          | meaning
// ST_IDLE        | after reset, no game; only cursor-free hidden board
// ST_WAIT_FIRST  | waiting for first eligible select of a pair
// ST_WAIT_SECOND | waiting for second eligible select of a pair
// ST_COMPARE     | one cycle: compare colors of the two picks
// ST_SHOW        | mismatched pair held visible until timer expires
// ST_DONE        | all pairs matched; holds until start
module match_controller
  import match_pkg::*;
#(
  parameter int NUM_SQ      = 8,
  parameter int IDX_W       = 3,
  parameter int COLOR_W     = 3,
  parameter int SHOW_CYCLES = 25_000_000
) (
  input  logic                      clk25MHz,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W-1:0]          cursor_idx,
  input  logic                      sel_pulse,
  input  logic [NUM_SQ*COLOR_W-1:0] color_map,
  output logic [2*NUM_SQ-1:0]       sq_state,
  output logic [IDX_W-1:0]          match_cnt,
  output logic                      busy,
  output logic                      game_over
`ifdef MOVE_COUNT_EN
  ,
  output logic [7:0]                move_cnt
`endif
);

  state_t             r_state, w_state_nxt;
  logic [NUM_SQ-1:0]  r_revealed, r_matched;
  logic [IDX_W-1:0]   r_first, r_second, r_match_cnt;
  logic               w_in_range, w_eligible, w_colors_eq, w_last_pair;
  logic               w_take_first, w_take_second, w_match, w_hide, w_clear;
  logic               w_timer_load, w_timer_done;

  assign w_in_range  = {1'b0, cursor_idx} < (IDX_W + 1)'(NUM_SQ);
  assign w_eligible  = w_in_range && !r_revealed[cursor_idx] && !r_matched[cursor_idx];
  assign w_colors_eq = color_map[r_first*COLOR_W +: COLOR_W] ==
                       color_map[r_second*COLOR_W +: COLOR_W];
  assign w_last_pair = (r_match_cnt + IDX_W'(1)) == IDX_W'(NUM_SQ / 2);

  // State register.
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes; start overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_take_first  = 1'b0;
    w_take_second = 1'b0;
    w_match       = 1'b0;
    w_hide        = 1'b0;
    w_clear       = 1'b0;
    w_timer_load  = 1'b0;
    if (start) begin
      w_clear     = 1'b1;
      w_state_nxt = ST_WAIT_FIRST;
    end else begin
      case (r_state)
        ST_WAIT_FIRST: if (sel_pulse && w_eligible) begin
          w_take_first = 1'b1;
          w_state_nxt  = ST_WAIT_SECOND;
        end
        ST_WAIT_SECOND: if (sel_pulse && w_eligible) begin
          w_take_second = 1'b1;
          w_state_nxt   = ST_COMPARE;
        end
        ST_COMPARE: if (w_colors_eq) begin
          w_match     = 1'b1;
          w_state_nxt = w_last_pair ? ST_DONE : ST_WAIT_FIRST;
        end else begin
          w_timer_load = 1'b1;
          w_state_nxt  = ST_SHOW;
        end
        ST_SHOW: if (w_timer_done) begin
          w_hide      = 1'b1;
          w_state_nxt = ST_WAIT_FIRST;
        end
        ST_IDLE, ST_DONE: w_state_nxt = r_state;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Square flags, pick latches and pair counter.
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      r_revealed  <= '0;
      r_matched   <= '0;
      r_first     <= '0;
      r_second    <= '0;
      r_match_cnt <= '0;
    end else if (w_clear) begin
      r_revealed  <= '0;
      r_matched   <= '0;
      r_match_cnt <= '0;
    end else begin
      if (w_take_first) begin
        r_first                <= cursor_idx;
        r_revealed[cursor_idx] <= 1'b1;
      end
      if (w_take_second) begin
        r_second               <= cursor_idx;
        r_revealed[cursor_idx] <= 1'b1;
      end
      if (w_match) begin
        r_matched[r_first]   <= 1'b1;
        r_matched[r_second]  <= 1'b1;
        r_revealed[r_first]  <= 1'b0;
        r_revealed[r_second] <= 1'b0;
        r_match_cnt          <= r_match_cnt + IDX_W'(1);
      end
      if (w_hide) begin
        r_revealed[r_first]  <= 1'b0;
        r_revealed[r_second] <= 1'b0;
      end
    end
  end

  show_timer #(
    .SHOW_CYCLES (SHOW_CYCLES)
  ) u_show_timer (
    .clk25MHz (clk25MHz),
    .rst      (rst),
    .i_load   (w_timer_load),
    .i_abort  (w_clear),
    .o_done   (w_timer_done)
  );

`ifdef MOVE_COUNT_EN
  logic [7:0] r_move_cnt;

  // One attempt per COMPARE, saturating at 255.
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      r_move_cnt <= '0;
    end else if (w_clear) begin
      r_move_cnt <= '0;
    end else if (r_state == ST_COMPARE && r_move_cnt != 8'hFF) begin
      r_move_cnt <= r_move_cnt + 8'd1;
    end
  end

  assign move_cnt = r_move_cnt;
`endif

  // Display mux: matched over revealed over cursor over hidden.
  always_comb begin
    sq_state = '0;
    for (int i = 0; i < NUM_SQ; i++) begin
      if (r_matched[i])
        sq_state[2*i +: 2] = SQ_MATCHED;
      else if (r_revealed[i])
        sq_state[2*i +: 2] = SQ_REVEALED;
      else if (r_state != ST_IDLE && cursor_idx == IDX_W'(i))
        sq_state[2*i +: 2] = SQ_CURSOR;
      else
        sq_state[2*i +: 2] = SQ_HIDDEN;
    end
  end

  assign match_cnt = r_match_cnt;
  assign busy      = (r_state == ST_COMPARE) || (r_state == ST_SHOW);
  assign game_over = (r_state == ST_DONE);

endmodule

// File: tb/tb_match_controller.sv
// Testbench for match_controller: stimulus pushes the predicted outputs
// of a rule-level game model into a queue; a monitor pops and compares
// one entry per clock. Build with MOVE_COUNT_EN to also check move_cnt.
module tb_match_controller;

  localparam int NUM_SQ = 8, IDX_W = 3, COLOR_W = 3, SHOW_CYCLES = 4;
  localparam int P_IDLE = 0, P_WF = 1, P_WS = 2, P_CMP = 3, P_SHOW = 4, P_DONE = 5;

  logic                      clk = 1'b0;
  logic                      rst_n, start, sel_pulse;
  logic [IDX_W-1:0]          cursor_idx;
  logic [NUM_SQ*COLOR_W-1:0] color_map;
  logic [2*NUM_SQ-1:0]       sq_state;
  logic [IDX_W-1:0]          match_cnt;
  logic                      busy, game_over;
`ifdef MOVE_COUNT_EN
  logic [7:0]                move_cnt;
`endif

  always #5 clk = ~clk;

  match_controller #(
    .NUM_SQ(NUM_SQ), .IDX_W(IDX_W), .COLOR_W(COLOR_W), .SHOW_CYCLES(SHOW_CYCLES)
  ) dut (
    .clk25MHz   (clk),
    .rst        (rst_n),
    .start      (start),
    .cursor_idx (cursor_idx),
    .sel_pulse  (sel_pulse),
    .color_map  (color_map),
    .sq_state   (sq_state),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .game_over  (game_over)
`ifdef MOVE_COUNT_EN
    ,
    .move_cnt   (move_cnt)
`endif
  );

  typedef struct packed {
    logic [15:0] sq;
    logic [2:0]  mc;
    logic        bsy;
    logic        go;
    logic [7:0]  mv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Game model expressed in terms of the rules, with a timestamp for the hide.
  int     m_phase, m_first, m_second, m_pairs, m_moves;
  bit     m_rev[NUM_SQ];
  bit     m_mat[NUM_SQ];
  longint m_cyc, m_show_end;

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int color_of(int i);
    return int'(color_map[i*COLOR_W +: COLOR_W]);
  endfunction

  function automatic bit eligible(int c);
    return c < NUM_SQ && !m_rev[c] && !m_mat[c];
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_pairs = 0; m_moves = 0; m_first = 0; m_second = 0;
    m_show_end = -1;
    for (int i = 0; i < NUM_SQ; i++) begin m_rev[i] = 0; m_mat[i] = 0; end
  endtask

  task automatic model_step(bit st, bit sl, int cur);
    m_cyc++;
    if (st) begin
      for (int i = 0; i < NUM_SQ; i++) begin m_rev[i] = 0; m_mat[i] = 0; end
      m_pairs = 0; m_moves = 0; m_show_end = -1; m_phase = P_WF;
    end else begin
      case (m_phase)
        P_WF: if (sl && eligible(cur)) begin
          m_first = cur; m_rev[cur] = 1; m_phase = P_WS;
        end
        P_WS: if (sl && eligible(cur)) begin
          m_second = cur; m_rev[cur] = 1; m_phase = P_CMP;
        end
        P_CMP: begin
          if (m_moves < 255) m_moves++;
          if (color_of(m_first) == color_of(m_second)) begin
            m_mat[m_first] = 1; m_mat[m_second] = 1;
            m_rev[m_first] = 0; m_rev[m_second] = 0;
            m_pairs++;
            m_phase = (m_pairs == NUM_SQ / 2) ? P_DONE : P_WF;
          end else begin
            m_show_end = m_cyc + SHOW_CYCLES;
            m_phase = P_SHOW;
          end
        end
        P_SHOW: if (m_cyc == m_show_end) begin
          m_rev[m_first] = 0; m_rev[m_second] = 0; m_phase = P_WF;
        end
        default: ;
      endcase
    end
  endtask

  function automatic exp_t predict(int cur);
    exp_t e;
    e.sq = '0;
    for (int i = 0; i < NUM_SQ; i++) begin
      if (m_mat[i])                         e.sq[2*i +: 2] = 2'd3;
      else if (m_rev[i])                    e.sq[2*i +: 2] = 2'd2;
      else if (m_phase != P_IDLE && i == cur) e.sq[2*i +: 2] = 2'd1;
    end
    e.mc  = 3'(m_pairs);
    e.bsy = (m_phase == P_CMP) || (m_phase == P_SHOW);
    e.go  = (m_phase == P_DONE);
    e.mv  = 8'(m_moves);
    return e;
  endfunction

  task automatic new_map();
    logic [2:0] c[NUM_SQ];
    logic [2:0] t;
    int j;
    if ($urandom_range(0, 3) != 0) begin
      for (int p = 0; p < NUM_SQ / 2; p++) begin
        c[2*p] = 3'($urandom_range(0, 7));
        c[2*p+1] = c[2*p];
      end
      for (int i = NUM_SQ - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = c[i]; c[i] = c[j]; c[j] = t;
      end
    end else begin
      for (int i = 0; i < NUM_SQ; i++) c[i] = 3'($urandom_range(0, 7));
    end
    for (int i = 0; i < NUM_SQ; i++) color_map[i*COLOR_W +: COLOR_W] = c[i];
  endtask

  // One clock of stimulus; a new color map only ever comes with start.
  task automatic cyc(bit st, bit sl, int cur, bit remap);
    @(negedge clk);
    if (st && remap) new_map();
    start = st; sel_pulse = sl; cursor_idx = cur[IDX_W-1:0];
    model_step(st, sl, cur);
    q.push_back(predict(cur));
  endtask

  task automatic idle(int n, int cur);
    repeat (n) cyc(0, 0, cur, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    start = 0; sel_pulse = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_sq_state", sq_state, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_game_over", game_over, 0);
`ifdef MOVE_COUNT_EN
    chk("rst_move_cnt", move_cnt, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick_cursor();
    int cands[$];
    if ($urandom_range(0, 1) == 0) return $urandom_range(0, NUM_SQ - 1);
    if (m_phase == P_WS)
      for (int j = 0; j < NUM_SQ; j++)
        if (eligible(j) && color_of(j) == color_of(m_first)) cands.push_back(j);
    if (cands.size() == 0)
      for (int j = 0; j < NUM_SQ; j++) if (eligible(j)) cands.push_back(j);
    if (cands.size() == 0) return $urandom_range(0, NUM_SQ - 1);
    return cands[$urandom_range(0, cands.size() - 1)];
  endfunction

  // Monitor: one expected entry per clock edge that stimulus accounted for.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sq_state", sq_state, e.sq);
      chk("match_cnt", match_cnt, e.mc);
      chk("busy", busy, e.bsy);
      chk("game_over", game_over, e.go);
`ifdef MOVE_COUNT_EN
      chk("move_cnt", move_cnt, e.mv);
`endif
    end
  end

  initial begin
    logic [2:0] dmap[NUM_SQ];
    dmap = '{3'd1, 3'd6, 3'd4, 3'd6, 3'd1, 3'd4, 3'd2, 3'd2};
    for (int i = 0; i < NUM_SQ; i++) color_map[i*COLOR_W +: COLOR_W] = dmap[i];
    rst_n = 1'b0; start = 0; sel_pulse = 0; cursor_idx = '0;
    m_cyc = 0;
    model_reset();
    #2;
    chk("por_sq_state", sq_state, 0);
    chk("por_match_cnt", match_cnt, 0);
    chk("por_busy", busy, 0);
    chk("por_game_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start: only the cursor square 0 shows.
    cyc(1, 0, 0, 0);
    idle(1, 0);
    // Matching pair 2/5.
    cyc(0, 1, 2, 0); cyc(0, 1, 5, 0); idle(2, 5);
    // Mismatch 0/1 with selects hammered during COMPARE/SHOW.
    cyc(0, 1, 0, 0); cyc(0, 1, 1, 0);
    repeat (SHOW_CYCLES + 1) cyc(0, 1, 3, 0);
    idle(1, 3);
    // Reselects on matched and on revealed squares.
    cyc(0, 1, 2, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 4, 0); idle(2, 4);
    // Finish the game.
    cyc(0, 1, 1, 0); cyc(0, 1, 3, 0); idle(2, 3);
    cyc(0, 1, 6, 0); cyc(0, 1, 7, 0); idle(2, 7);
    cyc(0, 1, 0, 0); idle(1, 0);
    cyc(1, 0, 0, 0); idle(1, 0);
    // Start aborts SHOW.
    cyc(0, 1, 0, 0); cyc(0, 1, 1, 0); idle(2, 1);
    cyc(1, 0, 1, 0); idle(SHOW_CYCLES + 1, 1);
    // Start and select together: start wins.
    cyc(1, 1, 3, 0); idle(1, 3);
    // Reset while waiting for the second pick.
    cyc(0, 1, 2, 0); idle(1, 2);
    mid_reset();
    cyc(1, 0, 0, 1);

    for (int k = 0; k < 3000; k++) begin
      bit st, sl;
      if (k == 1500) begin
        mid_reset();
        cyc(1, 0, 0, 1);
      end
      st = (m_phase == P_DONE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      sl = ($urandom_range(0, 2) == 0);
      cyc(st, sl, pick_cursor(), 1);
    end

    idle(2, 0);
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
